// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter: one-pair holding register plus an active pair, MSB-first on sd, ws leads data by one bit.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN: repeat the last pair on underrun instead of sending silence.
module i2s_tx_serializer #(
    parameter int WIDTH = 24,
    parameter int SLOT  = 32
) (
    input  logic             sck,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ws,
    output logic             sd,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);
    localparam int FRAME = 2 * SLOT;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] WS_FIRST = CW'(SLOT - 1);
    localparam logic [CW-1:0] WS_LAST  = CW'(FRAME - 2);

    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ws_reg, ws_next;
    logic             sd_reg, sd_next;
    logic             hold_full_reg, hold_full_next;
    logic [WIDTH-1:0] hold_left_reg, hold_left_next;
    logic [WIDTH-1:0] hold_right_reg, hold_right_next;
    logic [WIDTH-1:0] act_left_reg, act_left_next;
    logic [WIDTH-1:0] act_right_reg, act_right_next;
    logic             underrun_reg, underrun_next;
    logic [7:0]       underrun_cnt_reg, underrun_cnt_next;

    logic             frame_start;
    logic             accept;
    logic [WIDTH-1:0] left_hit;
    logic [WIDTH-1:0] right_hit;

    assign frame_start = (cnt_reg == CNT_LAST);
    assign accept      = in_valid & ~hold_full_reg;
    assign cnt_next    = frame_start ? '0 : cnt_reg + CW'(1);

    // One-hot bit selectors keyed on the count the next edge lands on; all-zero in the pad bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
        assign left_hit[gi]  = (cnt_next == CW'(WIDTH - 1 - gi));
        assign right_hit[gi] = (cnt_next == CW'(SLOT + WIDTH - 1 - gi));
    end

    always_comb begin
        hold_full_next    = hold_full_reg;
        hold_left_next    = hold_left_reg;
        hold_right_next   = hold_right_reg;
        act_left_next     = act_left_reg;
        act_right_next    = act_right_reg;
        underrun_next     = 1'b0;
        underrun_cnt_next = underrun_cnt_reg;

        if (frame_start) begin
            if (hold_full_reg) begin
                act_left_next  = hold_left_reg;
                act_right_next = hold_right_reg;
                hold_full_next = 1'b0;
            end else if (accept) begin
                // Bypass: a pair arriving exactly at frame start goes straight out.
                act_left_next  = in_left;
                act_right_next = in_right;
            end else begin
                underrun_next = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                act_left_next  = act_left_reg;
                act_right_next = act_right_reg;
`else
                act_left_next  = '0;
                act_right_next = '0;
`endif
            end
        end else if (accept) begin
            hold_left_next  = in_left;
            hold_right_next = in_right;
            hold_full_next  = 1'b1;
        end

        if (underrun_next && (underrun_cnt_reg != 8'hFF)) begin
            underrun_cnt_next = underrun_cnt_reg + 8'd1;
        end
    end

    assign ws_next = (cnt_next >= WS_FIRST) && (cnt_next <= WS_LAST);
    assign sd_next = (|(left_hit & act_left_next)) | (|(right_hit & act_right_next));

    always_ff @(negedge sck or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg          <= CNT_LAST;
            ws_reg           <= 1'b0;
            sd_reg           <= 1'b0;
            hold_full_reg    <= 1'b0;
            hold_left_reg    <= '0;
            hold_right_reg   <= '0;
            act_left_reg     <= '0;
            act_right_reg    <= '0;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= 8'd0;
        end else begin
            cnt_reg          <= cnt_next;
            ws_reg           <= ws_next;
            sd_reg           <= sd_next;
            hold_full_reg    <= hold_full_next;
            hold_left_reg    <= hold_left_next;
            hold_right_reg   <= hold_right_next;
            act_left_reg     <= act_left_next;
            act_right_reg    <= act_right_next;
            underrun_reg     <= underrun_next;
            underrun_cnt_reg <= underrun_cnt_next;
        end
    end

    assign in_ready     = ~hold_full_reg;
    assign ws           = ws_reg;
    assign sd           = sd_reg;
    assign underrun     = underrun_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Stereo I2S transmitter. Accepts parallel left/right sample pairs through a valid/ready handshake, buffers one pair, and serialises them MSB-first onto `sd`. It also generates the word-select line `ws` from `sck`. It sits directly upstream of the I2S receive/loopback stage and drives that stage's `ws` and `sd` inputs from the shared `sck`.

## Interface
- `WIDTH`, default 24: sample width in bits per channel.
- `SLOT`, default 32: bit clocks per channel slot; `SLOT >= WIDTH`, `SLOT >= 2`.
- `sck`, input, 1: bit clock. All state updates on the falling edge, so the downstream stage sees stable data on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_left`, input, WIDTH: left sample.
- `in_right`, input, WIDTH: right sample.
- `in_valid`, input, 1: sample pair present.
- `in_ready`, output, 1: holding register empty; pair accepted on a falling edge with `in_valid & in_ready`.
- `ws`, output, 1: word select; 0 = left, 1 = right. Registered.
- `sd`, output, 1: serial data. Registered.
- `underrun`, output, 1: one-cycle pulse when a frame starts with no data available.
- `underrun_cnt`, output, 8: saturating count of underruns.

## Operation
- Bit counter `cnt` runs 0 to 2*SLOT-1 and wraps. It advances one step per falling edge.
- Frame start is the edge on which `cnt` goes from 2*SLOT-1 to 0.
- Left data:
  - `cnt` 0 to WIDTH-1: left bits WIDTH-1 down to 0.
  - `cnt` WIDTH to SLOT-1: `sd` = 0.
- Right data:
  - `cnt` SLOT to SLOT+WIDTH-1: right bits, MSB first.
  - `cnt` SLOT+WIDTH to 2*SLOT-1: `sd` = 0.
- `ws` leads the data by one bit, per I2S:
  - `ws` = 1 for `cnt` in SLOT-1 to 2*SLOT-2.
  - `ws` = 0 otherwise, i.e. `cnt` = 2*SLOT-1 and 0 to SLOT-2.
- Buffering uses a holding register (one pair) and an active shift register (one pair). `in_ready` = holding register empty.
- Frame start, holding register full: the pair moves to the active register, the holding register empties, and `in_ready` rises after that edge.
- Frame start, holding register empty, accept on the same edge: the incoming pair is bypassed directly into the active register. There is no underrun and the holding register stays empty.
- Frame start, holding register empty, no accept: underrun.
  - `underrun` pulses high for one cycle.
  - `underrun_cnt` increments and saturates at 255.
  - The active register is filled according to the Configuration section.
- Accept at any other edge loads the holding register. `in_ready` drops after that edge.
- Reset, including mid-frame, takes effect immediately and aborts the frame in flight:
  - `cnt` = 2*SLOT-1
  - `ws` = 0, `sd` = 0
  - holding and active registers cleared
  - `in_ready` = 1, `underrun` = 0, `underrun_cnt` = 0

## Timing
- Handshake to first `sd` bit:
  - Pair accepted while the holding register is empty and not on a frame-start edge: the MSB appears on the next frame-start edge.
  - Worst case latency is 2*SLOT sck cycles.
- First frame start occurs on the first falling edge after reset deassertion.
- Throughput: one pair per 2*SLOT cycles. `in_ready` is low from accept until the following frame start.
- `ws` toggles every SLOT cycles. Its transitions occur one edge before each slot's MSB.

## Configuration
- `I2S_TX_REPEAT_ON_UNDERRUN_EN`
  - Defined: on underrun the active register reloads the last transmitted pair, so that pair is repeated. After reset the last pair is zero.
  - Undefined: on underrun the active register is loaded with zeros, so silence is sent.
  - The `underrun` pulse and `underrun_cnt` behave identically in both builds.

## Test plan
All scenarios use WIDTH=24, SLOT=32.
- Idle after reset, `in_valid`=0:
  - `ws` low for 31 edges, then high for 32, then low for 32, repeating; `sd`=0.
  - `underrun` pulses every 64 edges.
  - `underrun_cnt` reaches 255 after 255 frames and holds.
- Single pair left=0xA5A5A5, right=0x5A5A5A accepted at `cnt`=40:
  - Next frame: `sd` bits at `cnt` 0 to 23 = A5A5A5 MSB first; `cnt` 24 to 31 = 0; `cnt` 32 to 55 = 5A5A5A.
  - The receiver stage captures identical values.
- Backpressure: `in_valid` held high with three distinct pairs:
  - The second pair is accepted, then `in_ready` stays low until frame start.
  - Pairs are transmitted in order with no loss and no underrun.
- Bypass: pair 0x123456/0x654321 presented only on the frame-start edge with the holding register empty:
  - MSB sent on that edge.
  - `underrun` stays 0 and `in_ready` stays 1.
- Reset asserted at `cnt`=10 of the right slot with a pair held:
  - All outputs take their reset values immediately.
  - After release the held pair is gone and the first frame underruns.
- Underrun build check after pair 0xFFFFFF/0x000001 and no further input:
  - Macro defined: the pair repeats.
  - Macro undefined: zeros are sent.
  - In both builds `underrun_cnt`=1 after the first empty frame.
